// File: rtl/rom_seq_reader_pkg.sv
// rom_seq_reader_pkg: shared types and constants for the sequential ROM reader.
//   state_t      - reader FSM states (S_IDLE, S_RUN, S_DRAIN)
//   FIFO_DEPTH   - depth of the output skid FIFO (2: one word in hand + one in flight)
//   fifo_entry_t - {addr, data} FIFO entry at the default widths
package rom_seq_reader_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rom_seq_skid_fifo.sv
// rom_seq_skid_fifo: 2-entry synchronous FIFO used as the output skid buffer.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO, zeroes entries)
//   push, din  - write; accepted when not full, or when full and popping this cycle
//   pop, dout  - read; dout is the head entry, pop ignored when empty
//   count      - occupancy 0..2
//   full/empty - occupancy flags
module rom_seq_skid_fifo
  import rom_seq_reader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] e0_q, e0_d;   // head
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop, do_push;
  logic [1:0]   slot;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    do_pop  = pop && (cnt_q != 2'd0);
    do_push = push && ((cnt_q != 2'(FIFO_DEPTH)) || do_pop);
    // Slot the new word lands in, after the head has shifted out.
    slot    = cnt_q - {1'b0, do_pop};
    if (do_pop) e0_d = e1_q;
    if (do_push) begin
      if (slot == 2'd0) e0_d = din;
      else              e1_d = din;
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = e0_q;
  assign count = cnt_q;
  assign full  = (cnt_q == 2'(FIFO_DEPTH));
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/rom_seq_reader.sv
// rom_seq_reader: issues consecutive reads to a 1-cycle-latency synchronous ROM
// and streams the words out on a valid/ready interface.
//   clk, rst              - clock, synchronous active-high reset
//   start/start_addr/len  - transfer request (sampled in IDLE only); len 0..2**ADDR_W
//   rom_en/rom_addr       - ROM read port; rom_data returns the cycle after rom_en
//   out_valid/out_ready   - output handshake; out_data/out_addr = word and its address
//   busy                  - transfer in progress
//   done                  - 1-cycle completion pulse
// Optional (ROM_SEQ_READER_CHECKSUM_EN defined): csum = wrapping sum of the words
// accepted in the current transfer; cleared on start, valid with done.
module rom_seq_reader
  import rom_seq_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
`ifdef ROM_SEQ_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [ADDR_W:0]   REM_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
  logic              done_q, done_d;

  entry_t     fifo_din, fifo_dout;
  logic [1:0] fifo_count;
  logic       fifo_full, fifo_empty;
  logic       pop;
  logic [2:0] occ;

  assign fifo_din = '{addr: inflight_addr_q, data: rom_data};

  rom_seq_skid_fifo #(.W($bits(entry_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_dout.data;
  assign out_addr  = fifo_dout.addr;
  assign pop       = out_valid && out_ready;

  // Credits: FIFO slots already claimed by stored words plus the read in flight.
  // A word leaving this cycle frees its slot in time for a read issued now,
  // which is what keeps the stream at one word per cycle.
  assign occ    = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign rom_en = (state_q == S_RUN) && !fifo_full && (occ < 3'd2);

  assign rom_addr = addr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    inflight_d      = rom_en;
    inflight_addr_d = addr_q;
    done_d          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d  = S_RUN;
            addr_d   = start_addr;
            remain_d = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (rom_en) begin
          addr_d   = addr_q + ADDR_ONE;   // wraps modulo ROM depth
          remain_d = remain_q - REM_ONE;
          if (remain_q == REM_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last word leaving: nothing in flight and it is the only one stored.
        if (!inflight_q && pop && (fifo_count == 2'd1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      done_q          <= done_d;
    end
  end

`ifdef ROM_SEQ_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == S_IDLE) && start) csum_d = '0;
    else if (pop)                     csum_d = csum_q + out_data;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

endmodule
